// File: rtl/ffo_share_ctrl_if.sv
// ffo_share_ctrl_if: requester, engine and response signals around the shared FFO controller
interface ffo_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int W = 32,
  parameter int PW = 5,
  parameter int IDW = 2
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic eng_start;
  logic [W-1:0] eng_b;
  logic eng_ready;
  logic eng_v;
  logic [PW-1:0] eng_p;
  logic rsp_valid;
  logic rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic rsp_v;
  logic [PW-1:0] rsp_p;
  logic rsp_err;
  logic busy;
  modport master (
    input req_valid, req_data, eng_ready, eng_v, eng_p, rsp_ready,
    output req_ready, eng_start, eng_b, rsp_valid, rsp_id, rsp_v, rsp_p, rsp_err, busy
  );
  modport slave (
    output req_valid, req_data, eng_ready, eng_v, eng_p, rsp_ready,
    input req_ready, eng_start, eng_b, rsp_valid, rsp_id, rsp_v, rsp_p, rsp_err, busy
  );
endinterface

// File: rtl/ffo_share_ctrl.sv
// ffo_share_ctrl: round-robin sharing of one sequential find-first-one engine among NREQ requesters
module ffo_share_ctrl #(
  parameter int NREQ = 4,
  parameter int W = 32,
  parameter int PW = 5,
  parameter int IDW = 2,
  parameter int TIMEOUT = 80
) (
  input logic clock,
  input logic reset,
  ffo_share_ctrl_if.master bus
);
  localparam int WDW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;
  state_t state;
  logic [IDW-1:0] ptr, hold_id, gnt_id, off;
  logic [W-1:0] hold_data, gnt_data;
  logic [NREQ-1:0] rot;
  logic [IDW:0] sum;
  logic any, grant, wd_last;
  logic [WDW-1:0] wd;
  assign bus.eng_b = hold_data;
  assign bus.rsp_id = hold_id;
  assign wd_last = wd == WDW'(TIMEOUT - 1);
  assign grant = reset && state == IDLE && any && bus.eng_ready;
  assign bus.req_ready = grant ? NREQ'(1) << gnt_id : '0;
  // rotate requests so offset 0 is ptr, pick the lowest pending offset and map it back to an ID
  always_comb begin
    rot = NREQ'({bus.req_valid, bus.req_valid} >> ptr);
    off = '0;
    any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) begin off = IDW'(i); any = 1'b1; end
    sum = {1'b0, ptr} + {1'b0, off};
    gnt_id = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
    gnt_data = '0;
    for (int k = 0; k < NREQ; k++) if (gnt_id == IDW'(k)) gnt_data = bus.req_data[k*W +: W];
  end
  // grant, launch, wait under the watchdog, then hold the tagged response until accepted
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      wd <= '0;
      hold_data <= '0;
      hold_id <= '0;
      bus.eng_start <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_v <= 1'b0;
      bus.rsp_p <= '0;
      bus.rsp_err <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          hold_data <= gnt_data;
          hold_id <= gnt_id;
          bus.eng_start <= 1'b1;
          bus.busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          bus.eng_start <= 1'b0;
          wd <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          wd <= (wd == WDW'(TIMEOUT)) ? wd : wd + 1'b1;
          if (state == WAIT_DONE && bus.eng_ready) begin
            bus.rsp_v <= bus.eng_v;
            bus.rsp_p <= bus.eng_p;
            bus.rsp_err <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state <= RESP;
          end else if (wd_last) begin
            bus.rsp_v <= 1'b0;
            bus.rsp_p <= '0;
            bus.rsp_err <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state <= RESP;
          end else if (state == WAIT_BUSY && !bus.eng_ready) state <= WAIT_DONE;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          bus.busy <= 1'b0;
          ptr <= (hold_id == IDW'(NREQ - 1)) ? '0 : hold_id + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ffo_share_ctrl.sv
// tb_ffo_share_ctrl: directed stimulus with a response scoreboard for the shared FFO controller
module tb_ffo_share_ctrl;
  localparam int NREQ = 4, W = 32, PW = 5, IDW = 2, TIMEOUT = 80;
  typedef struct packed {
    logic [IDW-1:0] id;
    logic v;
    logic [PW-1:0] p;
    logic err;
  } rsp_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  ffo_share_ctrl_if #(.NREQ(NREQ), .W(W), .PW(PW), .IDW(IDW)) bus ();
  ffo_share_ctrl #(.NREQ(NREQ), .W(W), .PW(PW), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  rsp_t exp_q[$];
  int n_cmp = 0, n_err = 0, n_rsp = 0, cyc = 0, lat = 3, cnt = 0, n_start = 0;
  int gcnt[NREQ];
  int st_c, rv_c, base;
  logic hang = 1'b0;
  logic [NREQ-1:0] s_g;
  logic s_st, s_rv, s_busy;
  rsp_t s_rsp;
  logic [W-1:0] eng_word = '0;
  function automatic rsp_t mk(input int id, input logic v, input int p, input logic err);
    return {IDW'(id), v, PW'(p), err};
  endfunction
  // engine behaviour: word index 0 is the MSB, first set index wins, exhausted search reports W-1
  function automatic logic [PW:0] ffo(input logic [W-1:0] w);
    logic v;
    logic [PW-1:0] p;
    v = 1'b0;
    p = PW'(W - 1);
    for (int i = W - 1; i >= 0; i--) if (w[W-1-i]) begin v = 1'b1; p = PW'(i); end
    return {v, p};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // scoreboard monitor: every accepted response is matched against the oldest expectation
  always @(negedge clock) begin
    rsp_t got, want;
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      got = {bus.rsp_id, bus.rsp_v, bus.rsp_p, bus.rsp_err};
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got %0h expected none", got);
      end else begin
        want = exp_q.pop_front();
        chk("rsp", 64'(got), 64'(want));
      end
    end
  end
  // one clock: sample outputs mid-cycle, then after the edge retire grants and advance the engine model
  task automatic step();
    @(negedge clock);
    cyc++;
    s_g = bus.req_ready;
    s_st = bus.eng_start;
    s_rv = bus.rsp_valid;
    s_busy = bus.busy;
    s_rsp = {bus.rsp_id, bus.rsp_v, bus.rsp_p, bus.rsp_err};
    for (int k = 0; k < NREQ; k++) if (s_g[k]) gcnt[k]++;
    if (s_st) begin n_start++; eng_word = bus.eng_b; end
    @(posedge clock);
    #1;
    bus.req_valid = bus.req_valid & ~s_g;
    if (s_st) begin
      bus.eng_ready = 1'b0;
      cnt = lat;
    end else if (!bus.eng_ready && !hang && cnt > 0) begin
      if (cnt == 1) begin
        bus.eng_ready = 1'b1;
        {bus.eng_v, bus.eng_p} = ffo(eng_word);
      end
      cnt--;
    end
  endtask
  task automatic req(input int k, input logic [W-1:0] w, input rsp_t e);
    bus.req_data[k*W +: W] = w;
    bus.req_valid[k] = 1'b1;
    exp_q.push_back(e);
  endtask
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin step(); n++; end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d responses outstanding after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    step();
  endtask
  task automatic latency(input string name);
    st_c = -1000;
    rv_c = -1;
    for (int i = 0; i < 200 && rv_c < 0; i++) begin
      step();
      if (s_st) st_c = cyc;
      if (s_rv) rv_c = cyc;
    end
    chk(name, 64'(rv_c - st_c - 1), 64'(TIMEOUT));
  endtask
  initial begin
    bus.req_valid = 4'b0010;
    bus.req_data = '0;
    bus.eng_ready = 1'b1;
    bus.eng_v = 1'b0;
    bus.eng_p = '0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) gcnt[k] = 0;
    #12;
    chk("reset_busy", 64'(bus.busy), 0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 0);
    chk("reset_eng_start", 64'(bus.eng_start), 0);
    chk("reset_eng_b", 64'(bus.eng_b), 0);
    chk("reset_req_ready", 64'(bus.req_ready), 0);
    bus.req_valid = '0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    chk("post_reset_busy", 64'(s_busy), 0);
    base = n_rsp;
    req(0, 32'h0001_0000, mk(0, 1, 15, 0));
    drain(50);
    chk("t1_grant0", 64'(gcnt[0]), 1);
    chk("t1_grants", 64'(gcnt[1] + gcnt[2] + gcnt[3]), 0);
    chk("t1_starts", 64'(n_start), 1);
    chk("t1_rsp_count", 64'(n_rsp - base), 1);
    chk("t1_idle_busy", 64'(s_busy), 0);
    req(2, 32'h0000_0000, mk(2, 0, 31, 0));
    drain(50);
    req(3, 32'h0000_0001, mk(3, 1, 31, 0));
    drain(50);
    lat = 2;
    req(0, 32'h8000_0000, mk(0, 1, 0, 0));
    req(1, 32'h4000_0000, mk(1, 1, 1, 0));
    req(2, 32'h2000_0000, mk(2, 1, 2, 0));
    req(3, 32'h1000_0000, mk(3, 1, 3, 0));
    drain(100);
    req(1, 32'h0000_8000, mk(1, 1, 16, 0));
    req(3, 32'h0000_0100, mk(3, 1, 23, 0));
    drain(100);
    bus.rsp_ready = 1'b0;
    req(0, 32'h0400_0000, mk(0, 1, 5, 0));
    req(2, 32'h0000_0002, mk(2, 1, 30, 0));
    s_rv = 1'b0;
    for (int i = 0; i < 50 && !s_rv; i++) step();
    chk("t4_rsp_seen", 64'(s_rv), 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_hold", 64'({s_rv, s_rsp, s_g, s_st}), 64'({1'b1, mk(0, 1, 5, 0), NREQ'(0), 1'b0}));
    end
    bus.rsp_ready = 1'b1;
    step();
    step();
    chk("t4_regrant", 64'(s_g), 64'(4'b0100));
    drain(50);
    hang = 1'b1;
    req(1, 32'h0000_0004, mk(1, 0, 0, 1));
    latency("t5_wd_latency");
    hang = 1'b0;
    bus.eng_ready = 1'b1;
    cnt = 0;
    drain(10);
    lat = TIMEOUT - 1;
    req(2, 32'h0000_0800, mk(2, 1, 20, 0));
    latency("t5_race_latency");
    drain(10);
    lat = 20;
    bus.req_data[3*W +: W] = 32'hFFFF_FFFF;
    bus.req_valid[3] = 1'b1;
    repeat (8) step();
    chk("t6_busy_before", 64'(s_busy), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_busy", 64'(bus.busy), 0);
    chk("t6_eng_b", 64'(bus.eng_b), 0);
    chk("t6_outs", 64'({bus.rsp_valid, bus.eng_start, bus.req_ready}), 0);
    bus.eng_ready = 1'b1;
    cnt = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    chk("t6_busy_after", 64'(s_busy), 0);
    req(1, 32'h0000_0010, mk(1, 1, 27, 0));
    req(3, 32'h0200_0000, mk(3, 1, 6, 0));
    drain(100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
